// File: rtl/uart_rx_buffer_pkg.sv
// Shared UART receive-path constants: data width, default buffer depth and the
// bit layout of a stored entry {stop_err, parity_err, data}.
package uart_rx_buffer_pkg;

   localparam int UART_DATA_W     = 8;
   localparam int UART_FIFO_DEPTH = 16;

   // Error flags sit directly above the data field, in this order.
   localparam int ENTRY_DATA_LSB   = 0;
   localparam int ENTRY_PARITY_OFS = 0;
   localparam int ENTRY_STOP_OFS   = 1;
   localparam int ENTRY_FLAG_W     = 2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO. DEPTH must be a power of
// two; pointers carry one extra wrap bit to tell full from empty.
module uart_sync_fifo #(
   parameter int WIDTH  = 10,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              push_i,
   input  logic [WIDTH-1:0]  data_i,
   input  logic              pop_i,
   output logic [WIDTH-1:0]  data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [ADDR_W:0]   count_o
);

   localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_W:0]  r_wr_ptr;
   logic [ADDR_W:0]  r_rd_ptr;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                    (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

   // A pop in the same cycle frees the head slot, so a push into a full FIFO
   // is accepted whenever it coincides with a pop.
   assign w_pop  = pop_i & ~w_empty;
   assign w_push = push_i & (~w_full | w_pop);

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (clear_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   // NOTE: the storage array has no reset; the pointers alone define which
   // entries are valid, and a reset-free array maps onto plain RAM.
   always_ff @(posedge clk_i) begin
      if (w_push && !clear_i) r_mem[r_wr_ptr[ADDR_W-1:0]] <= data_i;
   end

   assign data_o  = r_mem[r_rd_ptr[ADDR_W-1:0]];
   assign full_o  = w_full;
   assign empty_o = w_empty;
   assign count_o = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive buffer behind the UART Rx path: captures one entry per rx_done pulse,
// queues it in a FWFT FIFO and flags characters dropped while the FIFO is full.
module uart_rx_buffer
   import uart_rx_buffer_pkg::*;
#(
   parameter int MAX_UART_DATA_W = UART_DATA_W,
   parameter int FIFO_DEPTH      = UART_FIFO_DEPTH,
   parameter int FIFO_ADDR_W     = $clog2(FIFO_DEPTH),
   parameter int ENTRY_W         = MAX_UART_DATA_W + ENTRY_FLAG_W
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        clear_i,
   input  logic                        rx_done_i,
   input  logic [MAX_UART_DATA_W-1:0]  rx_data_i,
   input  logic                        rx_parity_err_i,
   input  logic                        rx_stop_err_i,
   input  logic                        rd_ready_i,
   output logic                        rd_valid_o,
   output logic [MAX_UART_DATA_W-1:0]  rd_data_o,
   output logic                        rd_parity_err_o,
   output logic                        rd_stop_err_o,
   output logic [FIFO_ADDR_W:0]        count_o,
   output logic                        full_o,
   output logic                        empty_o,
   output logic                        overflow_o
);

   localparam int PARITY_BIT = MAX_UART_DATA_W + ENTRY_PARITY_OFS;
   localparam int STOP_BIT   = MAX_UART_DATA_W + ENTRY_STOP_OFS;

   logic               r_rx_done_q;
   logic               r_overflow;
   logic               w_wr_req;
   logic               w_rd_fire;
   logic               w_full;
   logic               w_empty;
   logic [ENTRY_W-1:0] w_wr_entry;
   logic [ENTRY_W-1:0] w_rd_entry;

   // Rising-edge detect so a multi-cycle done pulse yields a single write.
   assign w_wr_req  = rx_done_i & ~r_rx_done_q;
   assign w_rd_fire = ~w_empty & rd_ready_i;

   always_comb begin
      w_wr_entry                                           = '0;
      w_wr_entry[ENTRY_DATA_LSB +: MAX_UART_DATA_W]        = rx_data_i;
      w_wr_entry[PARITY_BIT]                               = rx_parity_err_i;
      w_wr_entry[STOP_BIT]                                 = rx_stop_err_i;
   end

   // The edge register keeps tracking through clear_i so a pulse spanning the
   // flush is not captured again afterwards.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rx_done_q <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_rx_done_q <= rx_done_i;
         if (clear_i)                               r_overflow <= 1'b0;
         else if (w_wr_req && w_full && !w_rd_fire) r_overflow <= 1'b1;
      end
   end

   uart_sync_fifo #(
      .WIDTH  (ENTRY_W),
      .DEPTH  (FIFO_DEPTH),
      .ADDR_W (FIFO_ADDR_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .push_i  (w_wr_req),
      .data_i  (w_wr_entry),
      .pop_i   (rd_ready_i),
      .data_o  (w_rd_entry),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (count_o)
   );

   assign rd_valid_o      = ~w_empty;
   assign rd_data_o       = w_rd_entry[ENTRY_DATA_LSB +: MAX_UART_DATA_W];
   assign rd_parity_err_o = w_rd_entry[PARITY_BIT];
   assign rd_stop_err_o   = w_rd_entry[STOP_BIT];
   assign full_o          = w_full;
   assign empty_o         = w_empty;
   assign overflow_o      = r_overflow;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer: inputs change and outputs are sampled on
// the falling clock edge; expected values are hand-computed constants.
module tb_uart_rx_buffer;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       clear_i = 1'b0;
   logic       rx_done_i = 1'b0;
   logic [7:0] rx_data_i = '0;
   logic       rx_parity_err_i = 1'b0;
   logic       rx_stop_err_i = 1'b0;
   logic       rd_ready_i = 1'b0;
   logic       rd_valid_o;
   logic [7:0] rd_data_o;
   logic       rd_parity_err_o;
   logic       rd_stop_err_o;
   logic [4:0] count_o;
   logic       full_o;
   logic       empty_o;
   logic       overflow_o;

   int n_checks = 0;
   int n_errors = 0;

   uart_rx_buffer dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .clear_i         (clear_i),
      .rx_done_i       (rx_done_i),
      .rx_data_i       (rx_data_i),
      .rx_parity_err_i (rx_parity_err_i),
      .rx_stop_err_i   (rx_stop_err_i),
      .rd_ready_i      (rd_ready_i),
      .rd_valid_o      (rd_valid_o),
      .rd_data_o       (rd_data_o),
      .rd_parity_err_o (rd_parity_err_o),
      .rd_stop_err_o   (rd_stop_err_o),
      .count_o         (count_o),
      .full_o          (full_o),
      .empty_o         (empty_o),
      .overflow_o      (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   // Raise rx_done for 'width' cycles, then hold it low one cycle so the edge
   // detector re-arms before the next character.
   task automatic send_char(input logic [7:0] d, input logic par, input logic stp,
                            input int width);
      rx_done_i = 1'b1; rx_data_i = d; rx_parity_err_i = par; rx_stop_err_i = stp;
      repeat (width) @(negedge clk_i);
      rx_done_i = 1'b0; rx_parity_err_i = 1'b0; rx_stop_err_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic pop_one();
      rd_ready_i = 1'b1;
      @(negedge clk_i);
      rd_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      n_checks++; if (rd_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b exp 0", rd_valid_o); end
      n_checks++; if (count_o !== 5'd0) begin n_errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
      n_checks++; if (empty_o !== 1'b1 || full_o !== 1'b0 || overflow_o !== 1'b0) begin
         n_errors++; $display("FAIL reset_flags got empty=%b full=%b ovf=%b exp 1 0 0", empty_o, full_o, overflow_o); end
   endtask

   task automatic test_single_char();
      rx_done_i = 1'b1; rx_data_i = 8'hA5;
      @(negedge clk_i);
      // One edge after the write: entry must already be visible.
      n_checks++; if (rd_valid_o !== 1'b1 || rd_data_o !== 8'hA5) begin
         n_errors++; $display("FAIL single_head got v=%b d=%h exp 1 a5", rd_valid_o, rd_data_o); end
      n_checks++; if (count_o !== 5'd1) begin n_errors++; $display("FAIL single_count got %0d exp 1", count_o); end
      rx_done_i = 1'b0;
      @(negedge clk_i);
      pop_one();
      n_checks++; if (empty_o !== 1'b1 || count_o !== 5'd0) begin
         n_errors++; $display("FAIL single_pop got empty=%b count=%0d exp 1 0", empty_o, count_o); end
   endtask

   task automatic test_wide_pulse();
      send_char(8'h3C, 1'b0, 1'b0, 5);
      n_checks++; if (count_o !== 5'd1 || rd_data_o !== 8'h3C) begin
         n_errors++; $display("FAIL wide_pulse got count=%0d d=%h exp 1 3c", count_o, rd_data_o); end
      pop_one();
      // Ready while empty must be ignored.
      pop_one();
      n_checks++; if (count_o !== 5'd0 || empty_o !== 1'b1) begin
         n_errors++; $display("FAIL ready_when_empty got count=%0d empty=%b exp 0 1", count_o, empty_o); end
   endtask

   task automatic fill16();
      for (int i = 0; i < 16; i++) send_char(8'(i), 1'b0, 1'b0, 1);
   endtask

   task automatic test_fill_overflow();
      fill16();
      n_checks++; if (full_o !== 1'b1 || count_o !== 5'd16 || overflow_o !== 1'b0) begin
         n_errors++; $display("FAIL fill_full got full=%b count=%0d ovf=%b exp 1 16 0", full_o, count_o, overflow_o); end
      send_char(8'hFF, 1'b0, 1'b0, 1);
      n_checks++; if (count_o !== 5'd16 || overflow_o !== 1'b1) begin
         n_errors++; $display("FAIL overflow got count=%0d ovf=%b exp 16 1", count_o, overflow_o); end
      for (int i = 0; i < 16; i++) begin
         n_checks++; if (rd_valid_o !== 1'b1 || rd_data_o !== 8'(i)) begin
            n_errors++; $display("FAIL drain_%0d got v=%b d=%h exp 1 %h", i, rd_valid_o, rd_data_o, 8'(i)); end
         pop_one();
      end
      n_checks++; if (empty_o !== 1'b1 || overflow_o !== 1'b1) begin
         n_errors++; $display("FAIL overflow_sticky got empty=%b ovf=%b exp 1 1", empty_o, overflow_o); end
      clear_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
      n_checks++; if (overflow_o !== 1'b0) begin n_errors++; $display("FAIL clear_ovf got %b exp 0", overflow_o); end
   endtask

   task automatic test_full_rw();
      fill16();
      rx_done_i = 1'b1; rx_data_i = 8'h77; rd_ready_i = 1'b1;
      @(negedge clk_i);
      rx_done_i = 1'b0; rd_ready_i = 1'b0;
      n_checks++; if (count_o !== 5'd16 || overflow_o !== 1'b0 || rd_data_o !== 8'h01) begin
         n_errors++; $display("FAIL full_rw got count=%0d ovf=%b head=%h exp 16 0 01", count_o, overflow_o, rd_data_o); end
      @(negedge clk_i);
      repeat (15) pop_one();
      n_checks++; if (count_o !== 5'd1 || rd_data_o !== 8'h77) begin
         n_errors++; $display("FAIL full_rw_tail got count=%0d d=%h exp 1 77", count_o, rd_data_o); end
      pop_one();
   endtask

   task automatic test_error_flags();
      send_char(8'h41, 1'b1, 1'b0, 1);
      send_char(8'h42, 1'b0, 1'b1, 1);
      n_checks++; if ({rd_data_o, rd_parity_err_o, rd_stop_err_o} !== {8'h41, 1'b1, 1'b0}) begin
         n_errors++; $display("FAIL flags_parity got d=%h p=%b s=%b exp 41 1 0", rd_data_o, rd_parity_err_o, rd_stop_err_o); end
      pop_one();
      n_checks++; if ({rd_data_o, rd_parity_err_o, rd_stop_err_o} !== {8'h42, 1'b0, 1'b1}) begin
         n_errors++; $display("FAIL flags_stop got d=%h p=%b s=%b exp 42 0 1", rd_data_o, rd_parity_err_o, rd_stop_err_o); end
      pop_one();
   endtask

   task automatic test_clear_priority();
      send_char(8'h10, 1'b0, 1'b0, 1);
      // Clear coinciding with a write and a read discards both.
      clear_i = 1'b1; rx_done_i = 1'b1; rx_data_i = 8'h20; rd_ready_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0; rd_ready_i = 1'b0;
      @(negedge clk_i);
      n_checks++; if (count_o !== 5'd0 || empty_o !== 1'b1) begin
         n_errors++; $display("FAIL clear_prio got count=%0d empty=%b exp 0 1", count_o, empty_o); end
      rx_done_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) send_char(8'(8'hC0 + i), 1'b0, 1'b0, 1);
      n_checks++; if (count_o !== 5'd5) begin n_errors++; $display("FAIL pre_reset_count got %0d exp 5", count_o); end
      #2 rst_ni = 1'b0;
      #1;
      n_checks++; if (rd_valid_o !== 1'b0 || count_o !== 5'd0 || empty_o !== 1'b1) begin
         n_errors++; $display("FAIL async_reset got v=%b count=%0d empty=%b exp 0 0 1", rd_valid_o, count_o, empty_o); end
      #1 rst_ni = 1'b1;
      @(negedge clk_i);
      send_char(8'h55, 1'b0, 1'b0, 1);
      n_checks++; if (rd_valid_o !== 1'b1 || rd_data_o !== 8'h55 || count_o !== 5'd1) begin
         n_errors++; $display("FAIL post_reset got v=%b d=%h count=%0d exp 1 55 1", rd_valid_o, rd_data_o, count_o); end
   endtask

   initial begin
      test_reset();
      test_single_char();
      test_wide_pulse();
      test_fill_overflow();
      test_full_rw();
      test_error_flags();
      test_clear_priority();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
- Receive-side buffer directly downstream of the UART controller's Rx path.
- Captures each received character and its parity/stop error flags when the controller pulses rx_done, and stores them in a FIFO.
- Presents entries to the host/bus side over a first-word-fall-through valid/ready interface.
- Decouples the host from UART character timing and flags overflow when the host falls behind.

Parameters:
- MAX_UART_DATA_W, 8, width of received data field (matches controller).
- FIFO_DEPTH, 16, number of entries; must be a power of two, >= 2.
- FIFO_ADDR_W, 4, = $clog2(FIFO_DEPTH); pointer index width.
- ENTRY_W, MAX_UART_DATA_W+2, stored entry width {stop_err, parity_err, data}.

Ports:
- clk_i  in  1  top clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous flush of FIFO and overflow flag
- rx_done_i  in  1  controller Rx done (pulse, may be >1 cycle wide)
- rx_data_i  in  MAX_UART_DATA_W  controller received data
- rx_parity_err_i  in  1  controller parity error for current character
- rx_stop_err_i  in  1  controller stop error for current character
- rd_ready_i  in  1  consumer accepts head entry this cycle
- rd_valid_o  out  1  head entry available
- rd_data_o  out  MAX_UART_DATA_W  head entry data
- rd_parity_err_o  out  1  head entry parity error flag
- rd_stop_err_o  out  1  head entry stop error flag
- count_o  out  FIFO_ADDR_W+1  current occupancy, 0..FIFO_DEPTH
- full_o  out  1  count_o == FIFO_DEPTH
- empty_o  out  1  count_o == 0
- overflow_o  out  1  sticky: a character was dropped

Behaviour:
- Reset (rst_ni low, async): pointers 0, count_o=0, empty_o=1, full_o=0, rd_valid_o=0, overflow_o=0, rx_done edge register=0. rd_data_o/flags are don't-care while rd_valid_o=0; storage array is not reset.
- Write detect: wr_req = rx_done_i & ~rx_done_q, where rx_done_q is rx_done_i registered. Exactly one write per done pulse regardless of pulse width.
- Data, parity and stop flags are sampled in the same cycle as wr_req.
- Read: rd_fire = rd_valid_o & rd_ready_i. rd_ready_i while empty is ignored.
- rd_valid_o = ~empty_o.
- rd_data_o and flags show mem[rd_ptr] combinationally from registered pointer and array. First-word-fall-through.
- Latency: wr_req sampled at edge N -> rd_valid_o=1 and data visible after edge N. No empty bypass.
- Pointers are FIFO_ADDR_W+1 bits, incremented modulo 2*FIFO_DEPTH.
  - full when the low bits are equal and the MSBs differ.
  - empty when the pointers are fully equal.
  - count_o = wr_ptr - rd_ptr, modulo arithmetic.
- Simultaneous wr_req and rd_fire, not full: both pointers advance; count unchanged.
- Simultaneous wr_req and rd_fire when full: read frees the slot; write accepted; count stays FIFO_DEPTH; no overflow.
- Simultaneous wr_req and rd_fire with count 1: both proceed; the new entry becomes head next cycle.
- wr_req when full without rd_fire: entry dropped, pointers unchanged, overflow_o set at the next edge. Stored entries are never overwritten.
- overflow_o stays set until clear_i or reset.
- clear_i: pointers to 0, overflow_o to 0, at the next edge. Highest priority; a coincident wr_req/rd_fire is discarded. rx_done_q still updates, so a pulse spanning clear_i is not re-captured.
- Reset asserted mid-operation: all state is lost immediately (async). After deassertion the block behaves as post-reset.

Decomposition:
- Shared header uart_defs.vh holds MAX_UART_DATA_W, the entry field offsets (data LSBs, parity at MAX_UART_DATA_W, stop at MAX_UART_DATA_W+1) and the default FIFO_DEPTH. The controller and its tx-side counterpart use the same header.
- Sub-module: uart_sync_fifo, a generic FWFT single-clock FIFO (WIDTH, DEPTH, ADDR_W; push, pop, clear, full, empty, count).
- uart_rx_buffer keeps the rx_done edge detect, entry packing/unpacking and sticky overflow.

Test Plan:
- Reset then single char: rx_done 1 cycle, data 0xA5, no errors -> next cycle rd_valid_o=1, rd_data_o=0xA5, count_o=1; rd_ready 1 cycle -> empty_o=1, count_o=0.
- Wide done pulse: rx_done_i high 5 cycles with data 0x3C -> exactly one entry, count_o=1.
- Fill and overflow: 16 chars 0x00..0x0F with rd_ready=0 -> full_o=1. 17th char 0xFF -> count_o=16, overflow_o=1. Drain returns 0x00..0x0F in order; overflow_o stays 1 until clear_i.
- Full plus simultaneous read/write: at full, rd_ready=1 in the wr_req cycle with data 0x77 -> 0x00 popped, 0x77 stored at tail, count_o=16, overflow_o=0.
- Error flags: char 0x41 with parity_err=1, then 0x42 with stop_err=1 -> the head shows the matching flag per entry, and the other flag is 0.
- Async reset mid-stream: 5 entries queued, rst_ni pulsed low between edges -> outputs reset immediately (rd_valid_o=0, count_o=0). After release, a new char 0x55 reads back correctly.
